// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and types for the receive parser and ARP reply transmitter.
package eth_pkg;

  typedef enum logic [1:0] {
    PKT_NONE     = 2'd0,
    PKT_ARP_REQ  = 2'd1,
    PKT_ARP_RESP = 2'd2,
    PKT_UDP      = 2'd3
  } pkt_type_t;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [15:0] ARP_OPER_REQ  = 16'd1;
  localparam logic [15:0] ARP_OPER_RESP = 16'd2;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam int PREAMBLE_LEN  = 7;
  localparam int FCS_LEN       = 4;
  localparam int ARP_HDR_BYTES = 42;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PREAMBLE,
    TX_SFD,
    TX_BODY,
    TX_FCS,
    TX_GAP
  } tx_state_t;

  typedef struct packed {
    logic [47:0] sha;
    logic [31:0] spa;
  } arp_req_t;

endpackage

// File: rtl/calc_crc32.sv
// Byte-wide Ethernet CRC-32 (reflected, init all-ones, inverted output).
// Dropping i_calc re-arms the accumulator for the next frame.
module calc_crc32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_calc,
  input  logic [7:0]  i_data,
  input  logic        i_vl,
  output logic [31:0] o_crc32
);

  logic [31:0] crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || !i_calc)
      crc <= '1;
    else if (i_vl)
      crc <= crc_step(crc, i_data);
  end

  assign o_crc32 = ~crc;

endmodule

// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: turns a matching ARP request strobe into a full
// Ethernet frame byte stream (preamble, header, ARP body, pad, FCS) with IPG.
module arp_reply_tx #(
  parameter int IPG_BYTES = 12,
  parameter int PAD_BYTES = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [1:0]  i_pkt_type,
  input  logic [47:0] i_SHA,
  input  logic [31:0] i_SPA,
  input  logic [31:0] i_TPA,
  output logic [7:0]  o_data,
  output logic        o_data_vl,
  output logic        o_busy,
  output logic [15:0] o_reply_cnt,
  output logic [15:0] o_drop_cnt
);
  import eth_pkg::*;

  localparam int          BODY_LEN  = ARP_HDR_BYTES + PAD_BYTES;
  localparam logic [10:0] HDR_END   = 11'(ARP_HDR_BYTES);
  localparam logic [10:0] BODY_LAST = 11'(BODY_LEN - 1);
  localparam logic [10:0] PRE_LAST  = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] FCS_LAST  = 11'(FCS_LEN - 1);
  localparam logic [10:0] GAP_LAST  = 11'(IPG_BYTES - 1);

  tx_state_t   state;
  logic [10:0] cnt;
  arp_req_t    act, pend, req;
  logic        pend_vl;
  logic        hit, start_new, last_fcs, calc;
  logic [7:0]  body_byte;
  logic [31:0] crc, fcs_word;

  // Header is laid out MSB-first as one vector; shifting by the byte index
  // brings the current byte to the top. Everything past the header is pad.
  function automatic logic [7:0] body_mux(input logic [10:0] idx, input arp_req_t r,
                                          input logic [47:0] mac, input logic [31:0] ip);
    logic [ARP_HDR_BYTES*8-1:0] hdr;
    logic [ARP_HDR_BYTES*8-1:0] sh;
    hdr = {r.sha, mac, ETH_TYPE_ARP,
           ARP_HTYPE_ETH, ETH_TYPE_IP, ARP_HLEN, ARP_PLEN, ARP_OPER_RESP,
           mac, ip, r.sha, r.spa};
    sh  = hdr << {idx, 3'b000};
    return (idx < HDR_END) ? sh[ARP_HDR_BYTES*8-1 -: 8] : 8'h00;
  endfunction

  assign req       = {i_SHA, i_SPA};
  assign hit       = i_enable && (pkt_type_t'(i_pkt_type) == PKT_ARP_REQ) && (i_TPA == i_self_ip);
  assign start_new = hit && (state == TX_IDLE) && !pend_vl;
  assign last_fcs  = (state == TX_FCS) && (cnt == FCS_LAST);
  assign calc      = (state == TX_BODY);
  assign body_byte = body_mux(cnt, act, i_self_mac, i_self_ip);

  calc_crc32 u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_calc  (calc),
    .i_data  (body_byte),
    .i_vl    (calc),
    .o_crc32 (crc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= TX_IDLE;
      cnt         <= '0;
      act         <= '0;
      pend        <= '0;
      pend_vl     <= 1'b0;
      fcs_word    <= '0;
      o_data      <= '0;
      o_data_vl   <= 1'b0;
      o_busy      <= 1'b0;
      o_reply_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      o_data      <= '0;
      o_data_vl   <= 1'b0;
      o_busy      <= (state != TX_IDLE);
      cnt         <= cnt + 11'd1;
      o_reply_cnt <= o_reply_cnt + {15'd0, last_fcs};

      unique case (state)
        TX_IDLE: begin
          if (pend_vl) begin
            act     <= pend;
            pend_vl <= 1'b0;
            state   <= TX_PREAMBLE;
            cnt     <= '0;
          end else if (start_new) begin
            act   <= req;
            state <= TX_PREAMBLE;
            cnt   <= '0;
          end
        end
        TX_PREAMBLE: begin
          o_data    <= PREAMBLE_BYTE;
          o_data_vl <= 1'b1;
          if (cnt == PRE_LAST) begin
            state <= TX_SFD;
            cnt   <= '0;
          end
        end
        TX_SFD: begin
          o_data    <= SFD_BYTE;
          o_data_vl <= 1'b1;
          state     <= TX_BODY;
          cnt       <= '0;
        end
        TX_BODY: begin
          o_data    <= body_byte;
          o_data_vl <= 1'b1;
          if (cnt == BODY_LAST) begin
            state <= TX_FCS;
            cnt   <= '0;
          end
        end
        TX_FCS: begin
          o_data_vl <= 1'b1;
          // The CRC register holds the finished word only during the first
          // FCS cycle (i_calc is already low), so freeze it there.
          unique case (cnt[1:0])
            2'd0: begin
              o_data   <= crc[7:0];
              fcs_word <= crc;
            end
            2'd1:    o_data <= fcs_word[15:8];
            2'd2:    o_data <= fcs_word[23:16];
            default: o_data <= fcs_word[31:24];
          endcase
          if (cnt == FCS_LAST) begin
            state <= TX_GAP;
            cnt   <= '0;
          end
        end
        TX_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (pend_vl) begin
              act     <= pend;
              pend_vl <= 1'b0;
              state   <= TX_PREAMBLE;
            end else begin
              state  <= TX_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state <= TX_IDLE;
          cnt   <= '0;
        end
      endcase

      // Anything not starting right away queues in the single slot or is lost.
      if (hit && !start_new) begin
        if (!pend_vl) begin
          pend    <= req;
          pend_vl <= 1'b1;
        end else begin
          o_drop_cnt <= o_drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_reply_tx.sv
// Directed + randomized bench for arp_reply_tx: frames are rebuilt from the
// ARP/Ethernet field layout and a bit-serial CRC-32, then compared byte by byte.
module tb_arp_reply_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [47:0] self_mac = 48'h02_00_00_00_00_01;
  logic [31:0] self_ip  = 32'hC0A8_010A;
  logic [1:0]  pkt_type = 2'd0;
  logic [47:0] sha = '0;
  logic [31:0] spa = '0;
  logic [31:0] tpa = '0;
  logic [7:0]  data;
  logic        data_vl, busy;
  logic [15:0] reply_cnt, drop_cnt;

  arp_reply_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_enable    (en),
    .i_self_mac  (self_mac),
    .i_self_ip   (self_ip),
    .i_pkt_type  (pkt_type),
    .i_SHA       (sha),
    .i_SPA       (spa),
    .i_TPA       (tpa),
    .o_data      (data),
    .o_data_vl   (data_vl),
    .o_busy      (busy),
    .o_reply_cnt (reply_cnt),
    .o_drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt = 0;
  int zero_err = 0;
  logic [7:0] cap_q[$];
  int         cap_t[$];
  logic       bsy_h [0:65535];
  logic [7:0] exp_q[$];
  logic [7:0] body_q[$];

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    bsy_h[ecnt[15:0]] <= busy;
    if (data_vl) begin
      cap_q.push_back(data);
      cap_t.push_back(ecnt);
    end else if (data != 8'h00) begin
      zero_err <= zero_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_raw();
    logic [31:0] c = 32'hFFFF_FFFF;
    logic fb;
    foreach (body_q[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ body_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return c;
  endfunction

  task automatic put(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) body_q.push_back(v[8*i +: 8]);
  endtask

  task automatic build_exp(input logic [47:0] r_sha, input logic [31:0] r_spa);
    logic [31:0] fcs;
    body_q.delete();
    exp_q.delete();
    put(r_sha, 6); put(self_mac, 6); put(64'h0806, 2);
    put(64'h0001, 2); put(64'h0800, 2); put(64'h06, 1); put(64'h04, 1); put(64'h0002, 2);
    put(self_mac, 6); put(self_ip, 4); put(r_sha, 6); put(r_spa, 4);
    repeat (18) body_q.push_back(8'h00);
    fcs = ~crc_raw();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body_q[i]) exp_q.push_back(body_q[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
  endtask

  function automatic logic [63:0] capb(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], cap_q[base + i]};
    return v;
  endfunction

  task automatic check_frame(input string tag, input int base,
                             input logic [47:0] r_sha, input logic [31:0] r_spa);
    int bad = 0;
    build_exp(r_sha, r_spa);
    chk({tag, "_len"}, 64'(cap_q.size() >= base + 72), 64'd1);
    if (cap_q.size() < base + 72) return;
    for (int i = 0; i < 72; i++) if (cap_q[base + i] !== exp_q[i]) bad++;
    chk({tag, "_bad_bytes"}, 64'(bad), 64'd0);
    chk({tag, "_contig"}, 64'(cap_t[base + 71] - cap_t[base]), 64'd71);
    chk({tag, "_fcs"}, capb(base + 68, 4), {32'd0, exp_q[68], exp_q[69], exp_q[70], exp_q[71]});
  endtask

  task automatic strobe(input logic [47:0] s_sha, input logic [31:0] s_spa,
                        input logic [31:0] s_tpa, input logic [1:0] ptype, output int e);
    @(negedge clk);
    sha = s_sha; spa = s_spa; tpa = s_tpa; pkt_type = ptype;
    @(posedge clk);
    #1;
    e = ecnt;
    pkt_type = 2'd0;
    sha = {16'($urandom()), $urandom()};
    spa = $urandom();
    tpa = self_ip;
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_t.delete();
  endtask

  localparam logic [47:0] REQ_SHA = 48'h00_11_22_33_44_55;
  localparam logic [31:0] REQ_SPA = 32'hC0A8_0164;

  initial begin
    int e1, e2, p, rtype, bz, exp_rep;
    logic [47:0] r1, r2, r3;
    logic [31:0] s1, s2, s3;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_vl", data_vl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reply", reply_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic reply
    clear_cap();
    strobe(REQ_SHA, REQ_SPA, self_ip, 2'd1, e1);
    repeat (100) @(negedge clk);
    chk("basic_count", 64'(cap_q.size()), 64'd72);
    chk("basic_start", 64'(cap_t[0]), 64'(e1 + 1));
    check_frame("basic", 0, REQ_SHA, REQ_SPA);
    chk("basic_dst", capb(8, 6), 64'h0000_0011_2233_4455);
    chk("basic_type", capb(20, 2), 64'h0806);
    chk("basic_oper", capb(28, 2), 64'h0002);
    chk("basic_tpa", capb(46, 4), 64'hC0A8_0164);
    bz = 0;
    for (int i = 50; i < 68; i++) if (cap_q[i] != 8'h00) bz++;
    chk("basic_pad", 64'(bz), 64'd0);
    chk("basic_reply", reply_cnt, 1);
    chk("basic_drop", drop_cnt, 0);

    // Loopback through a receive-side parse with the address roles swapped
    p = 0;
    while (p < cap_q.size() && cap_q[p] == 8'h55) p++;
    chk("lb_sfd", cap_q[p], 8'hD5);
    p++;
    rtype = 0;
    if (capb(p, 6) == {16'd0, REQ_SHA} && capb(p + 12, 2) == 64'h0806)
      rtype = (capb(p + 20, 2) == 64'd2) ? 2 : ((capb(p + 20, 2) == 64'd1) ? 1 : 0);
    chk("lb_type", 64'(rtype), 64'd2);
    chk("lb_sha", capb(p + 22, 6), {16'd0, self_mac});
    chk("lb_spa", capb(p + 28, 4), {32'd0, self_ip});
    chk("lb_tpa", capb(p + 38, 4), {32'd0, REQ_SPA});
    body_q.delete();
    for (int i = 0; i < 64; i++) body_q.push_back(cap_q[p + i]);
    chk("lb_crc_residue", crc_raw(), 32'hDEBB_20E3);

    // Randomized requests against the acceptance rules
    exp_rep = 1;
    for (int it = 0; it < 8; it++) begin
      logic [47:0] rs;
      logic [31:0] rp, rt;
      logic [1:0]  pt;
      logic        ren, expect_f;
      rs  = {16'($urandom()), $urandom()};
      rp  = $urandom();
      pt  = ($urandom_range(0, 9) < 7) ? 2'd1 : 2'($urandom_range(0, 3));
      rt  = ($urandom_range(0, 9) < 7) ? self_ip : $urandom();
      ren = ($urandom_range(0, 9) < 8);
      expect_f = ren && (pt == 2'd1) && (rt == self_ip);
      clear_cap();
      en = ren;
      strobe(rs, rp, rt, pt, e1);
      en = 1'b1;
      repeat (100) @(negedge clk);
      chk($sformatf("rnd%0d_count", it), 64'(cap_q.size()), expect_f ? 64'd72 : 64'd0);
      if (expect_f) begin
        exp_rep++;
        check_frame($sformatf("rnd%0d", it), 0, rs, rp);
      end
      chk($sformatf("rnd%0d_reply", it), reply_cnt, 16'(exp_rep));
    end

    // Filters
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_cap();
    strobe(REQ_SHA, REQ_SPA, 32'hC0A8_010B, 2'd1, e1);
    strobe(REQ_SHA, REQ_SPA, self_ip, 2'd3, e1);
    en = 1'b0;
    strobe(REQ_SHA, REQ_SPA, self_ip, 2'd1, e1);
    en = 1'b1;
    repeat (100) @(negedge clk);
    chk("filt_count", 64'(cap_q.size()), 64'd0);
    chk("filt_reply", reply_cnt, 0);
    chk("filt_drop", drop_cnt, 0);

    // Back-to-back: second queues, third is dropped
    r1 = {16'($urandom()), $urandom()}; s1 = $urandom();
    r2 = {16'($urandom()), $urandom()}; s2 = $urandom();
    r3 = {16'($urandom()), $urandom()}; s3 = $urandom();
    clear_cap();
    strobe(r1, s1, self_ip, 2'd1, e1);
    repeat (9) @(negedge clk);
    strobe(r2, s2, self_ip, 2'd1, e2);
    repeat (9) @(negedge clk);
    strobe(r3, s3, self_ip, 2'd1, e2);
    repeat (250) @(negedge clk);
    chk("b2b_count", 64'(cap_q.size()), 64'd144);
    check_frame("b2b_f1", 0, r1, s1);
    check_frame("b2b_f2", 72, r2, s2);
    chk("b2b_gap", 64'(cap_t[72] - cap_t[71]), 64'd13);
    chk("b2b_drop", drop_cnt, 1);
    chk("b2b_reply", reply_cnt, 2);
    bz = 0;
    for (int t = cap_t[0]; t <= cap_t[143] + 11; t++) if (bsy_h[t[15:0]] !== 1'b1) bz++;
    chk("b2b_busy_hold", 64'(bz), 64'd0);
    chk("b2b_busy_pre", bsy_h[16'(cap_t[0] - 1)], 1'b0);
    chk("b2b_busy_fall", bsy_h[16'(cap_t[143] + 14)], 1'b0);

    // Reset in the middle of BODY
    clear_cap();
    strobe(REQ_SHA, REQ_SPA, self_ip, 2'd1, e1);
    for (int k = 0; k < 300 && cap_q.size() < 39; k++) @(negedge clk);
    chk("mid_reach", 64'(cap_q.size() >= 39), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_vl", data_vl, 0);
    chk("mid_reply", reply_cnt, 0);
    chk("mid_drop", drop_cnt, 0);
    clear_cap();
    repeat (40) @(negedge clk);
    chk("mid_no_tail", 64'(cap_q.size()), 64'd0);
    r1 = {16'($urandom()), $urandom()}; s1 = $urandom();
    strobe(r1, s1, self_ip, 2'd1, e1);
    repeat (100) @(negedge clk);
    check_frame("mid_after", 0, r1, s1);
    chk("mid_after_reply", reply_cnt, 1);

    // Reply counter wrap
    @(negedge clk);
    force dut.o_reply_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.o_reply_cnt;
    @(negedge clk);
    chk("wrap_pre", reply_cnt, 16'hFFFF);
    clear_cap();
    strobe(REQ_SHA, REQ_SPA, self_ip, 2'd1, e1);
    repeat (100) @(negedge clk);
    chk("wrap_count", 64'(cap_q.size()), 64'd72);
    chk("wrap_reply", reply_cnt, 16'h0000);

    chk("idle_data_zero", 64'(zero_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arp_reply_tx.md
Name: arp_reply_tx

Overview:
- Transmit-side neighbour of the Ethernet receive parser.
- Consumes the parser's one-cycle ARP_REQ strobe and the captured SHA/SPA/TPA fields. When the request targets our IP, it emits a complete ARP reply frame as a byte stream toward the PHY TX path: preamble/SFD, MAC header, ARP body, padding and FCS.
- Holds one pending request while a frame is in flight, and enforces the inter-packet gap (IPG) between frames.

Parameters:
- IPG_BYTES, 12, idle cycles with o_data_vl low after the last FCS byte before the next frame may start.
- PAD_BYTES, 18, zero pad bytes after the ARP body (minimum 60-byte frame before FCS).

Ports:
- clk  in  1  byte clock, shared with the receive parser.
- rst_n  in  1  synchronous active-low reset.
- i_enable  in  1  0 = ignore new requests; a frame already in flight still completes.
- i_self_mac  in  48  our MAC address.
- i_self_ip  in  32  our IPv4 address.
- i_pkt_type  in  2  parser packet-type strobe: NONE=0, ARP_REQ=1, ARP_RESP=2, UDP=3.
- i_SHA  in  48  requester hardware address.
- i_SPA  in  32  requester protocol address.
- i_TPA  in  32  target protocol address.
- o_data  out  8  TX byte.
- o_data_vl  out  1  TX byte valid (TX enable).
- o_busy  out  1  high from frame start through the end of IPG.
- o_reply_cnt  out  16  count of frames fully sent; wraps at 16'hFFFF -> 0.
- o_drop_cnt  out  16  count of matching requests lost because the pending slot was full; wraps.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - o_data=0, o_data_vl=0, o_busy=0, both counters=0.
  - Pending slot empty; state IDLE.
  - Reset mid-frame aborts immediately. The next cycle shows o_data_vl=0, and no partial FCS is emitted.
- Accept condition:
  - i_enable=1, i_pkt_type==ARP_REQ and i_TPA==i_self_ip, sampled on the strobe cycle.
  - SHA and SPA are latched that same cycle. Inputs on all other cycles are ignored.
  - If state is IDLE and the slot is empty: latch into the active registers and start.
  - Else if the slot is empty: latch into the pending slot.
  - Else: drop the request and increment o_drop_cnt.
- Latency: strobe sampled at edge N; first preamble byte on o_data with o_data_vl=1 after edge N+1; o_busy rises with it.
- States: IDLE -> PREAMBLE(7 x 8'h55) -> SFD(1 x 8'hD5) -> BODY(60 bytes) -> FCS(4) -> GAP(IPG_BYTES) -> IDLE.
  - At the end of GAP, a pending request moves to active and the next state is PREAMBLE directly, with no extra IDLE cycle.
  - o_busy drops only when GAP exits to IDLE.
- BODY byte order, all fields MSB byte first:
  - dst=req SHA, src=i_self_mac, type 16'h0806.
  - HTYPE 16'h0001, PTYPE 16'h0800, HLEN 8'h06, PLEN 8'h04, OPER 16'h0002.
  - SHA=i_self_mac, SPA=i_self_ip, THA=req SHA, TPA=req SPA.
  - Then PAD_BYTES x 8'h00.
- i_self_mac and i_self_ip are sampled live during BODY; they must be static during operation.
- Byte counter: 11 bits, cleared on every state change, incremented each cycle; one byte per cycle, with no gaps inside a frame.
- CRC:
  - i_calc is high for exactly the 60 BODY cycles, with the BODY byte fed on i_data and i_vl=1.
  - i_calc is low during PREAMBLE/SFD/FCS/GAP, which resets the CRC between frames.
  - FCS bytes are sent crc32[7:0] first, then [15:8], [23:16], [31:24]. The word is captured at BODY->FCS, so the FCS stays stable while the CRC unit is released.
- o_reply_cnt increments on the cycle the last FCS byte is driven.
- o_data=0 whenever o_data_vl=0.

Decomposition:
- Shared package eth_pkg:
  - pkt_type enum (NONE/ARP_REQ/ARP_RESP/UDP).
  - ETH_TYPE_ARP=16'h0806, ETH_TYPE_IP=16'h0800.
  - ARP_OPER_REQ=1, ARP_OPER_RESP=2.
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
  - The TX state enum lives here too.
- Sub-module: the existing calc_crc32 (clk, rst_n, i_calc, i_data, i_vl, o_crc32), instantiated once.
- The body byte mux is a local combinational function of the byte counter.

Test Plan:
- Common setup for all scenarios: self_mac=02:00:00:00:00:01, self_ip=C0A8010A. One ARP_REQ strobe with TPA=C0A8010A, SHA=00:11:22:33:44:55, SPA=C0A80164.
- Basic reply: apply the strobe.
  - Exactly 72 consecutive valid bytes starting 2 edges after the strobe.
  - Bytes 8..13 = 00 11 22 33 44 55; bytes 20..21 = 08 06; OPER bytes 28..29 = 00 02; bytes 46..49 = C0 A8 01 64; bytes 50..67 = 00.
  - FCS matches the bench CRC-32 model; o_reply_cnt=1.
- Loopback: feed the output into the receive parser with self_mac/self_ip swapped.
  - Parser reports ARP_RESP, SHA=02:00:00:00:00:01, SPA=C0A8010A, and a CRC OK.
- Filter: strobe with TPA=C0A8010B, with i_pkt_type=UDP, and with i_enable=0.
  - o_data_vl stays 0 and both counters stay 0.
- Back-to-back: three matching strobes 10 cycles apart.
  - Two frames are sent, separated by exactly 12 idle cycles; the second frame carries the second request's SHA.
  - o_drop_cnt=1; o_busy stays high continuously from first frame start to second frame end + 12.
- Reset mid-frame: pull rst_n low at BODY byte 30 for 1 cycle.
  - o_data_vl=0 the next cycle and all counters return to 0.
  - A new strobe afterward produces a full frame with a correct FCS.
- Counter wrap: force o_reply_cnt to FFFF, then send one frame; o_reply_cnt reads 0000.
